// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_pkg
//  Purpose  : Shared types for the stepper-motor datapath: run-state encoding
//             and the sign-flag triple derived from a signed count.
//  Revision : 1.0  initial release
// ============================================================================
package stepper_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic negative;
        logic positive;
        logic zero;
    } flags_t;

    // Callers pass the sign bit and the OR-reduction of the value, which keeps
    // the helper independent of the count width.
    function automatic flags_t sign_flags(input logic msb, input logic nonzero);
        flags_t f;
        f.negative = msb;
        f.positive = !msb && nonzero;
        f.zero     = !nonzero;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_count_register.sv
`default_nettype none
// ============================================================================
//  Module   : step_count_register
//  Purpose  : Signed step-count register with manual load/inc/dec and a
//             tick-driven run mode that walks the count toward zero.
//  Revision : 1.0  initial release
// ============================================================================
module step_count_register
    import stepper_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             increment,
    input  logic             decrement,
    input  logic             run,
    input  logic             tick,
    input  logic             abort,
    output logic [WIDTH-1:0] value,
    output logic             negative,
    output logic             positive,
    output logic             zero,
    output logic             busy,
    output logic             step,
    output logic             dir,
    output logic             done,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    flags_t           r_flags;
    logic             r_step;
    logic             r_dir;
    logic             r_done;
    logic             r_overflow;

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_step_value;
    logic [WIDTH-1:0] w_inc_limit;
    logic [WIDTH-1:0] w_dec_limit;
    logic             w_is_zero;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_value;
    flags_t           w_next_flags;
    logic             w_next_step;
    logic             w_next_dir;
    logic             w_next_done;
    logic             w_next_overflow;

    assign w_inc        = r_value + c_one;
    assign w_dec        = r_value - c_one;
    assign w_is_zero    = (r_value == '0);
    // Auto-steps always move toward zero, so they can never cross an extreme.
    assign w_step_value = r_value[WIDTH-1] ? w_inc : w_dec;

    generate
        if (SATURATE) begin : g_saturate
            assign w_inc_limit = c_max;
            assign w_dec_limit = c_min;
        end else begin : g_wrap
            assign w_inc_limit = c_min;
            assign w_dec_limit = c_max;
        end
    endgenerate

    always_comb begin
        w_next_state    = r_state;
        w_next_value    = r_value;
        w_next_step     = 1'b0;
        w_next_dir      = r_dir;
        w_next_done     = 1'b0;
        w_next_overflow = r_overflow;
        case (r_state)
            IDLE: begin
                if (!abort) begin
                    if (run) begin
                        if (w_is_zero) begin
                            w_next_done = 1'b1;
                        end else begin
                            w_next_state = RUN;
                        end
                    end else if (load) begin
                        w_next_value    = data;
                        w_next_overflow = 1'b0;
                    end else if (increment) begin
                        if (r_value == c_max) begin
                            w_next_value    = w_inc_limit;
                            w_next_overflow = 1'b1;
                        end else begin
                            w_next_value = w_inc;
                        end
                    end else if (decrement) begin
                        if (r_value == c_min) begin
                            w_next_value    = w_dec_limit;
                            w_next_overflow = 1'b1;
                        end else begin
                            w_next_value = w_dec;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (tick) begin
                    w_next_value = w_step_value;
                    w_next_step  = 1'b1;
                    w_next_dir   = r_value[WIDTH-1];
                    if (w_step_value == '0) begin
                        w_next_state = IDLE;
                        w_next_done  = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Flags come from the same next value as the count so they never lag it.
    assign w_next_flags = sign_flags(w_next_value[WIDTH-1], |w_next_value);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_value    <= '0;
            r_flags    <= sign_flags(1'b0, 1'b0);
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_value    <= w_next_value;
            r_flags    <= w_next_flags;
            r_step     <= w_next_step;
            r_dir      <= w_next_dir;
            r_done     <= w_next_done;
            r_overflow <= w_next_overflow;
        end
    end

    assign value    = r_value;
    assign negative = r_flags.negative;
    assign positive = r_flags.positive;
    assign zero     = r_flags.zero;
    assign busy     = (r_state == RUN);
    assign step     = r_step;
    assign dir      = r_dir;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_step_count_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_count_register
//  Purpose  : Scoreboard bench for a saturating and a wrapping instance driven
//             by shared stimulus, checked against an integer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_count_register;

    localparam int W    = 8;
    localparam int MAXV = 127;
    localparam int MINV = -128;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0, increment = 1'b0, decrement = 1'b0;
    logic         run = 1'b0, tick = 1'b0, abort = 1'b0;
    logic [W-1:0] data = '0;

    logic [W-1:0] value_s, value_w;
    logic neg_s, pos_s, zero_s, busy_s, step_s, dir_s, done_s, ovf_s;
    logic neg_w, pos_w, zero_w, busy_w, step_w, dir_w, done_w, ovf_w;

    always #5 clk = ~clk;

    step_count_register #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .load(load), .data(data),
        .increment(increment), .decrement(decrement), .run(run), .tick(tick),
        .abort(abort), .value(value_s), .negative(neg_s), .positive(pos_s),
        .zero(zero_s), .busy(busy_s), .step(step_s), .dir(dir_s),
        .done(done_s), .overflow(ovf_s)
    );

    step_count_register #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .load(load), .data(data),
        .increment(increment), .decrement(decrement), .run(run), .tick(tick),
        .abort(abort), .value(value_w), .negative(neg_w), .positive(pos_w),
        .zero(zero_w), .busy(busy_w), .step(step_w), .dir(dir_w),
        .done(done_w), .overflow(ovf_w)
    );

    typedef struct {
        int       value;
        bit [7:0] fl;   // {neg,pos,zero,busy,step,dir,done,ovf}
    } exp_t;

    exp_t qs[$];
    exp_t qw[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state, index 0 = saturating instance, 1 = wrapping instance
    int m_cnt[2];
    bit m_run[2];
    bit m_ovf[2];
    bit m_dir[2];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_ovf[i] = 0; m_dir[i] = 0;
        end
    endfunction

    function automatic exp_t model_step(input int i, input bit ld, input int d,
                                        input bit inc, input bit dec, input bit rn,
                                        input bit tk, input bit ab);
        exp_t e;
        bit   stp = 0;
        bit   dn  = 0;
        bit   sat = (i == 0);
        if (!m_run[i]) begin
            if (!ab) begin
                if (rn) begin
                    if (m_cnt[i] != 0) m_run[i] = 1;
                    else               dn = 1;
                end else if (ld) begin
                    m_cnt[i] = d;
                    m_ovf[i] = 0;
                end else if (inc) begin
                    if (m_cnt[i] == MAXV) begin
                        m_ovf[i] = 1;
                        m_cnt[i] = sat ? MAXV : MINV;
                    end else m_cnt[i] = m_cnt[i] + 1;
                end else if (dec) begin
                    if (m_cnt[i] == MINV) begin
                        m_ovf[i] = 1;
                        m_cnt[i] = sat ? MINV : MAXV;
                    end else m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end else if (ab) begin
            m_run[i] = 0;
        end else if (tk) begin
            m_dir[i] = (m_cnt[i] < 0);
            m_cnt[i] = m_cnt[i] + (m_dir[i] ? 1 : -1);
            stp = 1;
            if (m_cnt[i] == 0) begin
                m_run[i] = 0;
                dn = 1;
            end
        end
        e.value = m_cnt[i];
        e.fl = {(m_cnt[i] < 0), (m_cnt[i] > 0), (m_cnt[i] == 0), m_run[i],
                stp, m_dir[i], dn, m_ovf[i]};
        return e;
    endfunction

    task automatic cyc(input bit ld, input int d, input bit inc, input bit dec,
                       input bit rn, input bit tk, input bit ab);
        @(negedge clk);
        load = ld; data = W'(d); increment = inc; decrement = dec;
        run = rn; tick = tk; abort = ab;
        qs.push_back(model_step(0, ld, d, inc, dec, rn, tk, ab));
        qw.push_back(model_step(1, ld, d, inc, dec, rn, tk, ab));
    endtask

    task automatic check_reset_outputs();
        check("reset value sat", int'($signed(value_s)), 0);
        check("reset flags sat", int'({neg_s, pos_s, zero_s, busy_s, step_s, dir_s, done_s, ovf_s}), 8'h20);
        check("reset value wrap", int'($signed(value_w)), 0);
        check("reset flags wrap", int'({neg_w, pos_w, zero_w, busy_w, step_w, dir_w, done_w, ovf_w}), 8'h20);
    endtask

    // Monitor: one expected entry per clock while stimulus is active
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qs.size() > 0) begin
                e = qs.pop_front();
                check("value sat", int'($signed(value_s)), e.value);
                check("flags sat", int'({neg_s, pos_s, zero_s, busy_s, step_s, dir_s, done_s, ovf_s}), int'(e.fl));
            end
            if (qw.size() > 0) begin
                e = qw.pop_front();
                check("value wrap", int'($signed(value_w)), e.value);
                check("flags wrap", int'({neg_w, pos_w, zero_w, busy_w, step_w, dir_w, done_w, ovf_w}), int'(e.fl));
            end
        end
    end

    initial begin
        int r;
        int d;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;

        // load 5 then count down to zero
        cyc(1, 5, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0, 0, 0);
        // run from -3 with tick held
        cyc(1, -3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 1, 0);
        // extremes and overflow clearing
        cyc(1, 127, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, -128, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // partial run then abort racing a tick
        cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // run at zero, then manual commands ignored while running
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0, 0);
        cyc(1, 50, 0, 0, 1, 0, 0);
        cyc(1, 50, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 1, 0);
        // longest run from the most negative value
        cyc(1, -128, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        repeat (130) cyc(0, 0, 0, 0, 0, 1, 0);

        // randomized traffic with extremes favoured
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 3);
            d = (r == 0) ? MAXV : (r == 1) ? MINV : ($urandom_range(0, 255) - 128);
            r = $urandom_range(0, 99);
            cyc(r < 10, d, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                (r >= 10) && (r < 20), $urandom_range(0, 9) < 6,
                $urandom_range(0, 24) == 0);
        end

        // asynchronous reset in the middle of a run
        cyc(1, 7, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("busy before reset", int'(busy_s), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 1, 0);

        repeat (2) @(negedge clk);
        check("queue drained", qs.size() + qw.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
